// File: rtl/reg_f_arb_pkg.sv
// Shared constants, state codes and select-legality helper for the reg_f arbiter.
package reg_f_arb_pkg;

  localparam int WIDTH_D = 8;
  localparam int SIZE_D  = 9;
  localparam int SELW_D  = $clog2(SIZE_D);

  localparam logic [3:0] PORT_RD_SEL = 4'h8;
  localparam logic [3:0] PORT_WR_SEL = 4'hF;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB_IDLE  = 1'b0;
  localparam arb_state_t ARB_GRANT = 1'b1;

  // PORT_WR_SEL is a write-only alias; reads of the port go through index SIZE-1.
  function automatic logic sel_legal(input int unsigned sel, input logic we, input int unsigned size);
    return (sel < size) || (we && (sel == 32'(PORT_WR_SEL)));
  endfunction

endpackage

// File: rtl/reg_f_arb_if.sv
// Requester-side bundle of the reg_f arbiter; lock exists only with REG_F_ARB_LOCK_EN.
interface reg_f_arb_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int SELW  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*SELW-1:0]  sel_bus;
  logic [NREQ*WIDTH-1:0] wdata_bus;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      rdata;
  logic                  rvalid;
  logic                  err;
`ifdef REG_F_ARB_LOCK_EN
  logic [NREQ-1:0]       lock;

  modport master (output req, we, sel_bus, wdata_bus, lock, input gnt, rdata, rvalid, err);
  modport slave  (input req, we, sel_bus, wdata_bus, lock, output gnt, rdata, rvalid, err);
`else
  modport master (output req, we, sel_bus, wdata_bus, input gnt, rdata, rvalid, err);
  modport slave  (input req, we, sel_bus, wdata_bus, output gnt, rdata, rvalid, err);
`endif
endinterface

// File: rtl/reg_f_arb_rr_pick.sv
// Combinational round-robin picker: first set req scanning upward from ptr with wrap.
// Zero latency; no backpressure (pure function of req and ptr).
module reg_f_arb_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int          jj;
  logic [PW-1:0] j;

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    jj  = 0;
    j   = '0;
    for (int i = 0; i < NREQ; i++) begin
      jj = int'(ptr) + i;
      if (jj >= NREQ) jj = jj - NREQ;
      j = PW'(jj);
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = j;
        win[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_f_arb.sv
// Round-robin sequencer sharing one reg_f port; grant 1 cycle after req, rdata/rvalid 2 cycles after.
// Requesters hold req until gnt; REG_F_ARB_LOCK_EN adds lock[] for atomic re-grant bursts.
module reg_f_arb
  import reg_f_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int SIZE  = SIZE_D,
  parameter int NREQ  = 2,
  parameter int SELW  = SELW_D
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_f_arb_if.slave       bus,
  output logic             rf_en,
  output logic [SELW-1:0]  rf_sel,
  output logic [WIDTH-1:0] rf_in,
  input  logic [WIDTH-1:0] rf_out
);

  localparam int PW = $clog2(NREQ);

  arb_state_t       state_q;
  logic [PW-1:0]    ptr_q;
  logic [NREQ-1:0]  gnt_q;
  logic             rd_pend_q;
  logic             rvalid_q;
  logic             err_q;
  logic [WIDTH-1:0] rdata_q;

  logic             hold;
  logic [NREQ-1:0]  pick_req;
  logic [NREQ-1:0]  win_oh;
  logic [PW-1:0]    win_idx;
  logic             win_any;
  logic             we_w;
  logic [SELW-1:0]  sel_w;
  logic [WIDTH-1:0] dat_w;
  logic             legal_w;
  logic             rd_done;

`ifdef REG_F_ARB_LOCK_EN
  assign hold = (state_q == ARB_GRANT) && |(gnt_q & bus.req & bus.lock);
`else
  assign hold = 1'b0;
`endif

  // A locked owner is re-picked by restricting the picker to the current grant.
  assign pick_req = hold ? gnt_q : bus.req;

  reg_f_arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .win (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    we_w  = 1'b0;
    sel_w = '0;
    dat_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        we_w  = bus.we[i];
        sel_w = bus.sel_bus[i*SELW +: SELW];
        dat_w = bus.wdata_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  assign legal_w = sel_legal(32'(sel_w), we_w, SIZE);
  assign rd_done = (state_q == ARB_GRANT) && rd_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rf_en     <= 1'b0;
      rf_sel    <= '0;
      rf_in     <= '0;
    end else begin
      rvalid_q <= rd_done;
      if (rd_done) rdata_q <= rf_out;

      if (win_any) begin
        state_q   <= ARB_GRANT;
        gnt_q     <= win_oh;
        rf_sel    <= sel_w;
        rf_in     <= dat_w;
        rf_en     <= we_w & legal_w;
        rd_pend_q <= ~we_w & legal_w;
        err_q     <= ~legal_w;
        if (!hold) ptr_q <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
      end else begin
        state_q   <= ARB_IDLE;
        gnt_q     <= '0;
        rf_en     <= 1'b0;
        rd_pend_q <= 1'b0;
        err_q     <= 1'b0;
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;

endmodule
